// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) and CP0 Random counter.
// Optional: define TLB_OP_PROBE_TIMEOUT_EN to add a probe-grant timeout and the probe_timeout port.
module tlb_op_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_type,
    input  logic             flush,
    input  logic [31:0]      cp0_index,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_we,
    input  logic [31:0]      cp0_entryhi,
    input  logic [31:0]      cp0_entrylo0,
    input  logic [31:0]      cp0_entrylo1,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_idx,
    output logic [31:0]      tlb_wdata_hi,
    output logic [31:0]      tlb_wdata_lo0,
    output logic [31:0]      tlb_wdata_lo1,
    input  logic [31:0]      tlb_rdata_hi,
    input  logic [31:0]      tlb_rdata_lo0,
    input  logic [31:0]      tlb_rdata_lo1,
    output logic             probe_req,
    output logic [18:0]      probe_vpn2,
    output logic [7:0]       probe_asid,
    input  logic             probe_grant,
    input  logic             probe_hit,
    input  logic [IDX_W-1:0] probe_hit_idx,
    output logic             done_valid,
    output logic             done_index_we,
    output logic [31:0]      done_index,
    output logic             done_entry_we,
    output logic [31:0]      done_entryhi,
    output logic [31:0]      done_entrylo0,
    output logic [31:0]      done_entrylo1,
`ifdef TLB_OP_PROBE_TIMEOUT_EN
    output logic             probe_timeout,
`endif
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_ENTRIES - 1);
    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        PROBE_REQ,
        PROBE_WAIT,
        DONE
    } state_t;

    state_t state;
    logic   accept;

    // Index bits above IDX_W and the EntryHi gap bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8]};

    assign accept = op_valid && op_ready && !flush;

    // Random reloads to the top entry and never wanders below Wired.
    always_ff @(posedge clk) begin
        if (!rst) begin
            random <= MAX_IDX;
        end else if (wired_we || (cp0_wired >= MAX_IDX) || (random <= cp0_wired)) begin
            random <= MAX_IDX;
        end else begin
            random <= random - 1'b1;
        end
    end

    // TLB read data lands in DONE, so the read result is steered straight from the array.
    assign done_entryhi  = done_entry_we ? tlb_rdata_hi  : 32'd0;
    assign done_entrylo0 = done_entry_we ? tlb_rdata_lo0 : 32'd0;
    assign done_entrylo1 = done_entry_we ? tlb_rdata_lo1 : 32'd0;

`ifdef TLB_OP_PROBE_TIMEOUT_EN
    logic [7:0] probe_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            op_ready      <= 1'b1;
            tlb_we        <= 1'b0;
            tlb_idx       <= '0;
            tlb_wdata_hi  <= 32'd0;
            tlb_wdata_lo0 <= 32'd0;
            tlb_wdata_lo1 <= 32'd0;
            probe_req     <= 1'b0;
            probe_vpn2    <= 19'd0;
            probe_asid    <= 8'd0;
            done_valid    <= 1'b0;
            done_index_we <= 1'b0;
            done_index    <= 32'd0;
            done_entry_we <= 1'b0;
`ifdef TLB_OP_PROBE_TIMEOUT_EN
            probe_cnt     <= 8'd0;
            probe_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_ready <= 1'b0;
                        case (op_type)
                            OP_TLBP: begin
                                probe_req  <= 1'b1;
                                probe_vpn2 <= cp0_entryhi[31:13];
                                probe_asid <= cp0_entryhi[7:0];
                                state      <= PROBE_REQ;
                            end
                            OP_TLBR: begin
                                tlb_idx <= cp0_index[IDX_W-1:0];
                                state   <= READ;
                            end
                            OP_TLBWI, OP_TLBWR: begin
                                tlb_we        <= 1'b1;
                                tlb_idx       <= (op_type == OP_TLBWR) ? random
                                                                        : cp0_index[IDX_W-1:0];
                                tlb_wdata_hi  <= cp0_entryhi;
                                tlb_wdata_lo0 <= cp0_entrylo0;
                                tlb_wdata_lo1 <= cp0_entrylo1;
                                state         <= WRITE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end

                // A started write is committed regardless of flush.
                WRITE: begin
                    tlb_we     <= 1'b0;
                    done_valid <= 1'b1;
                    state      <= DONE;
                end

                READ: begin
                    if (flush) begin
                        op_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        done_valid    <= 1'b1;
                        done_entry_we <= 1'b1;
                        state         <= DONE;
                    end
                end

                PROBE_REQ: begin
                    if (flush) begin
                        probe_req <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= IDLE;
`ifdef TLB_OP_PROBE_TIMEOUT_EN
                        probe_cnt <= 8'd0;
`endif
                    end else if (probe_grant) begin
                        probe_req <= 1'b0;
                        state     <= PROBE_WAIT;
`ifdef TLB_OP_PROBE_TIMEOUT_EN
                        probe_cnt <= 8'd0;
`endif
                    end
`ifdef TLB_OP_PROBE_TIMEOUT_EN
                    else if (probe_cnt == 8'd254) begin
                        probe_req     <= 1'b0;
                        probe_cnt     <= 8'd0;
                        probe_timeout <= 1'b1;
                        done_valid    <= 1'b1;
                        done_index_we <= 1'b1;
                        done_index    <= 32'h8000_0000;
                        state         <= DONE;
                    end else begin
                        probe_cnt <= probe_cnt + 8'd1;
                    end
`endif
                end

                PROBE_WAIT: begin
                    if (flush) begin
                        op_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        done_valid    <= 1'b1;
                        done_index_we <= 1'b1;
                        done_index    <= probe_hit ? {{(32-IDX_W){1'b0}}, probe_hit_idx}
                                                   : 32'h8000_0000;
                        state         <= DONE;
                    end
                end

                DONE: begin
                    done_valid    <= 1'b0;
                    done_index_we <= 1'b0;
                    done_entry_we <= 1'b0;
                    op_ready      <= 1'b1;
                    state         <= IDLE;
`ifdef TLB_OP_PROBE_TIMEOUT_EN
                    probe_timeout <= 1'b0;
`endif
                end

                default: begin
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: TLB array and probe port modelled here, results checked by scoreboard monitors.
module tb_tlb_op_ctrl;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk, rst;
    logic          op_valid, op_ready, flush, wired_we;
    logic [1:0]    op_type;
    logic [31:0]   cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
    logic [IW-1:0] cp0_wired, tlb_idx, probe_hit_idx, random;
    logic          tlb_we, probe_req, probe_grant, probe_hit;
    logic [31:0]   tlb_wdata_hi, tlb_wdata_lo0, tlb_wdata_lo1;
    logic [31:0]   tlb_rdata_hi, tlb_rdata_lo0, tlb_rdata_lo1;
    logic [18:0]   probe_vpn2;
    logic [7:0]    probe_asid;
    logic          done_valid, done_index_we, done_entry_we;
    logic [31:0]   done_index, done_entryhi, done_entrylo0, done_entrylo1;
`ifdef TLB_OP_PROBE_TIMEOUT_EN
    logic          probe_timeout;
`endif

    tlb_op_ctrl #(.TLB_ENTRIES(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type), .flush(flush),
        .cp0_index(cp0_index), .cp0_wired(cp0_wired), .wired_we(wired_we),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .tlb_we(tlb_we), .tlb_idx(tlb_idx),
        .tlb_wdata_hi(tlb_wdata_hi), .tlb_wdata_lo0(tlb_wdata_lo0), .tlb_wdata_lo1(tlb_wdata_lo1),
        .tlb_rdata_hi(tlb_rdata_hi), .tlb_rdata_lo0(tlb_rdata_lo0), .tlb_rdata_lo1(tlb_rdata_lo1),
        .probe_req(probe_req), .probe_vpn2(probe_vpn2), .probe_asid(probe_asid),
        .probe_grant(probe_grant), .probe_hit(probe_hit), .probe_hit_idx(probe_hit_idx),
        .done_valid(done_valid), .done_index_we(done_index_we), .done_index(done_index),
        .done_entry_we(done_entry_we), .done_entryhi(done_entryhi),
        .done_entrylo0(done_entrylo0), .done_entrylo1(done_entrylo1),
`ifdef TLB_OP_PROBE_TIMEOUT_EN
        .probe_timeout(probe_timeout),
`endif
        .random(random)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // TLB array model: registered read, one-cycle read latency
    logic [31:0] arr_hi[N], arr_lo0[N], arr_lo1[N];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                arr_hi[i]  <= 32'd0;
                arr_lo0[i] <= 32'd0;
                arr_lo1[i] <= 32'd0;
            end
            arr_hi[3]  <= 32'hABCD_E0FF;
            arr_lo0[3] <= 32'h0000_0A5F;
            arr_lo1[3] <= 32'h0000_0B6F;
        end else if (tlb_we) begin
            arr_hi[tlb_idx]  <= tlb_wdata_hi;
            arr_lo0[tlb_idx] <= tlb_wdata_lo0;
            arr_lo1[tlb_idx] <= tlb_wdata_lo1;
        end
        tlb_rdata_hi  <= arr_hi[tlb_idx];
        tlb_rdata_lo0 <= arr_lo0[tlb_idx];
        tlb_rdata_lo1 <= arr_lo1[tlb_idx];
    end

    // scoreboard
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        idx_we;
        logic [31:0] idx;
        logic        ent_we;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } done_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   hi;
        logic [31:0]   lo0;
        logic [31:0]   lo1;
    } wr_t;

    done_t exp_q[$];
    wr_t   exp_wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && done_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                done_t e;
                e = exp_q.pop_front();
                check("done_index_we", 32'(done_index_we), 32'(e.idx_we));
                check("done_entry_we", 32'(done_entry_we), 32'(e.ent_we));
                if (e.idx_we) check("done_index", done_index, e.idx);
                if (e.ent_we) begin
                    check("done_entryhi", done_entryhi, e.hi);
                    check("done_entrylo0", done_entrylo0, e.lo0);
                    check("done_entrylo1", done_entrylo1, e.lo1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && tlb_we) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tlb_we actual=1 expected=0");
            end else begin
                wr_t w;
                w = exp_wr_q.pop_front();
                check("wr_idx", 32'(tlb_idx), 32'(w.idx));
                check("wr_hi", tlb_wdata_hi, w.hi);
                check("wr_lo0", tlb_wdata_lo0, w.lo0);
                check("wr_lo1", tlb_wdata_lo1, w.lo1);
            end
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic issue(input logic [1:0] t, input logic [31:0] idx, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1);
        op_valid     = 1'b1;
        op_type      = t;
        cp0_index    = idx;
        cp0_entryhi  = hi;
        cp0_entrylo0 = lo0;
        cp0_entrylo1 = lo1;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] t, input logic [31:0] idx, input logic [31:0] hi,
                            input logic [31:0] lo0, input logic [31:0] lo1,
                            input logic [IW-1:0] exp_idx, input logic flush_mid);
        exp_wr_q.push_back('{idx: exp_idx, hi: hi, lo0: lo0, lo1: lo1});
        exp_q.push_back('{idx_we: 1'b0, idx: 32'd0, ent_we: 1'b0, hi: 32'd0, lo0: 32'd0, lo1: 32'd0});
        issue(t, idx, hi, lo0, lo1);
        check("write_we_pulse", 32'(tlb_we), 32'd1);
        check("write_idx", 32'(tlb_idx), 32'(exp_idx));
        flush = flush_mid;
        @(negedge clk);
        flush = 1'b0;
        check("write_we_one_cycle", 32'(tlb_we), 32'd0);
        check("write_done_latency", 32'(done_valid), 32'd1);
        @(negedge clk);
        check("write_done_one_cycle", 32'(done_valid), 32'd0);
        check("write_back_idle", 32'(op_ready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] idx, input logic [IW-1:0] exp_idx,
                           input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        exp_q.push_back('{idx_we: 1'b0, idx: 32'd0, ent_we: 1'b1, hi: hi, lo0: lo0, lo1: lo1});
        issue(2'b01, idx, 32'h0, 32'h0, 32'h0);
        check("read_idx", 32'(tlb_idx), 32'(exp_idx));
        check("read_no_early_done", 32'(done_valid), 32'd0);
        @(negedge clk);
        check("read_done_latency", 32'(done_valid), 32'd1);
        @(negedge clk);
        check("read_done_one_cycle", 32'(done_valid), 32'd0);
    endtask

    task automatic do_probe(input logic [18:0] vpn2, input logic [7:0] asid, input int delay,
                            input logic hit, input logic [IW-1:0] hidx, input logic [31:0] exp_index);
        exp_q.push_back('{idx_we: 1'b1, idx: exp_index, ent_we: 1'b0, hi: 32'd0, lo0: 32'd0, lo1: 32'd0});
        issue(2'b00, 32'h0, {vpn2, 5'b0, asid}, 32'h0, 32'h0);
        for (int i = 0; i <= delay; i++) begin
            check("probe_req_held", 32'(probe_req), 32'd1);
            if (i == 0 || i == delay) begin
                check("probe_vpn2", 32'(probe_vpn2), 32'(vpn2));
                check("probe_asid", 32'(probe_asid), 32'(asid));
            end
            if (i == delay) probe_grant = 1'b1;
            @(negedge clk);
        end
        probe_grant = 1'b0;
        check("probe_req_dropped", 32'(probe_req), 32'd0);
        probe_hit     = hit;
        probe_hit_idx = hidx;
        @(negedge clk);
        probe_hit     = 1'b0;
        probe_hit_idx = '0;
        check("probe_done_latency", 32'(done_valid), 32'd1);
        @(negedge clk);
        check("probe_done_one_cycle", 32'(done_valid), 32'd0);
    endtask

    // stimulus
    initial begin
        rst = 1'b0; op_valid = 1'b0; op_type = 2'b00; flush = 1'b0; wired_we = 1'b0;
        cp0_index = 32'd0; cp0_wired = '0; cp0_entryhi = 32'd0;
        cp0_entrylo0 = 32'd0; cp0_entrylo1 = 32'd0;
        probe_grant = 1'b0; probe_hit = 1'b0; probe_hit_idx = '0;
        repeat (3) @(negedge clk);

        check("rst_random", 32'(random), 32'd15);
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_tlb_we", 32'(tlb_we), 32'd0);
        check("rst_probe_req", 32'(probe_req), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_index_we", 32'(done_index_we), 32'd0);
        check("rst_done_entry_we", 32'(done_entry_we), 32'd0);
        check("rst_done_index", done_index, 32'd0);
        check("rst_tlb_idx", 32'(tlb_idx), 32'd0);
        check("rst_probe_vpn2", 32'(probe_vpn2), 32'd0);

        // wired=0: 15 down to 0 then wrap to 15
        rst = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            logic [IW-1:0] e;
            e = IW'(15 - i);
            check("random_wired0", 32'(random), 32'(e));
            @(negedge clk);
        end

        // wired=5: 15..5 repeating
        cp0_wired = 4'd5;
        wired_we  = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("random_wired5", 32'(random), 32'(15 - (i % 11)));
            @(negedge clk);
        end
        wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        check("random_wired_we_reload", 32'(random), 32'd15);
        @(negedge clk);
        check("random_after_reload", 32'(random), 32'd14);
        @(negedge clk);

        // TLBWR captures current Random (13)
        check("random_before_tlbwr", 32'(random), 32'd13);
        do_write(2'b11, 32'd2, 32'h1234_A011, 32'h0000_5555, 32'h0000_6666, 4'd13, 1'b0);

        // TLBWI index 7, then read it back
        do_write(2'b10, 32'd7, 32'h0007_E0AA, 32'h0000_1234, 32'h0000_4321, 4'd7, 1'b0);
        do_read(32'd7, 4'd7, 32'h0007_E0AA, 32'h0000_1234, 32'h0000_4321);

        // TLBR of preloaded entry 3, out-of-range index bits ignored
        do_read(32'h0000_0013, 4'd3, 32'hABCD_E0FF, 32'h0000_0A5F, 32'h0000_0B6F);

        // TLBP hit and miss, grant delayed 4 cycles
        do_probe(19'h5_A5A5, 8'h3C, 4, 1'b1, 4'd9, 32'h0000_0009);
        do_probe(19'h1_2345, 8'hC3, 4, 1'b0, 4'd5, 32'h8000_0000);
        do_probe(19'h7_FFFF, 8'hFF, 0, 1'b1, 4'd15, 32'h0000_000F);

        // flush in PROBE_REQ: back to idle, no result
        issue(2'b00, 32'h0, 32'hDEAD_B011, 32'h0, 32'h0);
        check("flush_probe_req_high", 32'(probe_req), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_probe_idle", 32'(op_ready), 32'd1);
        check("flush_probe_req_drop", 32'(probe_req), 32'd0);
        repeat (3) @(negedge clk);

        // flush in READ: no result
        issue(2'b01, 32'd3, 32'h0, 32'h0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_read_idle", 32'(op_ready), 32'd1);
        check("flush_read_no_done", 32'(done_valid), 32'd0);
        repeat (2) @(negedge clk);

        // flush during WRITE: write and done still happen
        do_write(2'b10, 32'd11, 32'h000B_E001, 32'h0000_0B0B, 32'h0000_0C0C, 4'd11, 1'b1);

        // flush coincident with accept: op is dropped
        op_valid = 1'b1; op_type = 2'b10; cp0_index = 32'd4; flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        check("flush_accept_ready", 32'(op_ready), 32'd1);
        check("flush_accept_no_we", 32'(tlb_we), 32'd0);
        @(negedge clk);
        check("flush_accept_no_we2", 32'(tlb_we), 32'd0);

        // reset in the middle of TLBR
        issue(2'b01, 32'd3, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_no_done", 32'(done_valid), 32'd0);
        check("midrst_random", 32'(random), 32'd15);
        check("midrst_ready", 32'(op_ready), 32'd1);
        repeat (3) @(negedge clk);

        check("pending_done", 32'(exp_q.size()), 32'd0);
        check("pending_writes", 32'(exp_wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
